comm_cmd_arbiter: RTL and testbench
===================================

Name: comm_cmd_arbiter

Overview:
- Shares one 16-bit command transmitter (UART, high byte sent first, two bytes per command) between NUM_REQ requesters.
- Round-robin arbitration; latches the winning command and holds it stable on cmd for the whole transmission.
- Pulses snd_cmd once, waits for cmd_cmplt, acks the requester, then enforces a minimum inter-command gap.
- Sits between the command sources (e.g. navigation and test logic) and the command master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_W, 16, command width (must be 16 for the current transmitter)
GAP_CYC, 0, idle clocks inserted after each cmd_cmplt before the next grant (0 = none)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level; held until its ack
req_cmd  in  NUM_REQ*CMD_W  packed commands; requester i occupies [CMD_W*i+CMD_W-1 : CMD_W*i]
ack  out  NUM_REQ  one-cycle pulse on ack[i] when requester i's command is fully transmitted
busy  out  1  high in any state other than IDLE
cur_id  out  clog2(NUM_REQ)  index of the current/last granted requester
snd_cmd  out  1  one-cycle start pulse to the command master
cmd  out  CMD_W  command to the transmitter, registered, stable from snd_cmd through cmd_cmplt
cmd_cmplt  in  1  one-cycle completion pulse from the command master

Behaviour:
- Clocking: one clock (clk). Reset (rst_n) is asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE, snd_cmd=0, ack=0, busy=0, cmd=0, cur_id=0, rr pointer=0, gap counter=0.
- States:
  - IDLE: if any req bit is set, grant the first set bit searching from ptr upward, wrapping modulo NUM_REQ. On the same edge: load cmd from that requester's slice, load cur_id, go to LAUNCH. If no req bit is set, stay in IDLE.
  - LAUNCH: snd_cmd=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold cmd and cur_id. On cmd_cmplt=1: pulse ack[cur_id] in the following cycle, set ptr=(cur_id+1) mod NUM_REQ, go to GAP if GAP_CYC>0, else IDLE.
  - GAP: count GAP_CYC cycles, then go to IDLE. No grants are made in GAP.
- Latency:
  - req first sampled high in IDLE at edge N gives snd_cmd=1 in cycle N+1.
  - cmd_cmplt sampled at edge M gives ack in cycle M+1; the next snd_cmd is no earlier than M+3+GAP_CYC.
- cmd must not change between snd_cmd and cmd_cmplt, because the transmitter reads the high byte live. The latched copy guarantees this; changes on req_cmd after the grant are ignored.
- Requester contract: req must be low by the cycle after ack. If req is still high in the next IDLE, it is a new request and is sent again.
- Request dropped before grant: it is not served. Request dropped after grant: the command is still sent and ack is still pulsed.
- cmd_cmplt outside WAIT (IDLE, LAUNCH, GAP): ignored, with no ack and no state change.
- Simultaneous requests: exactly one grant per transaction. Starvation-free; each requester waits at most NUM_REQ-1 other commands.
- Pointer wrap: with ptr=NUM_REQ-1 and req[NUM_REQ-1]=0, the search wraps to 0.
- Reset mid-operation (any state): immediate return to reset values. No ack for the in-flight command. The transmitter shares rst_n.
- ack is one-hot or zero and never coincides with snd_cmd.

Test Plan:
- Single request: req=4'b0010, req_cmd slice1=16'hA55A -> snd_cmd one cycle after req, cmd=16'hA55A, cur_id=1; after cmd_cmplt, ack=4'b0010 for one cycle, busy falls.
- Round robin: req=4'b1111 held, each requester drops req after its ack -> grant order 0,1,2,3; then re-raise req[0] and req[3] -> next grant is 0 (ptr wrapped after 3).
- Fairness: req[0] re-asserted immediately after every ack, req[2] steady -> grants alternate 0,2,0,2; no requester waits more than one command.
- Stability: change req_cmd slice0 from 16'h1234 to 16'hFFFF after the grant -> cmd stays 16'h1234 until cmd_cmplt; a real transmitter bench receives bytes 8'h12 then 8'h34.
- Gap and stray: GAP_CYC=5, two back-to-back requests -> exactly 5 idle cycles between ack and the next grant cycle; a cmd_cmplt pulsed in IDLE/GAP produces no ack.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs at reset values immediately, no ack; after release, a still-held req is re-granted from ptr=0.

Source files
------------

// File: rtl/comm_cmd_arbiter_if.sv
// Command-arbiter bus: requester side plus the command-master handshake.
// The arbiter takes master; the surrounding logic takes slave.
interface comm_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic                     snd_cmd;
  logic [CMD_W-1:0]         cmd;
  logic                     cmd_cmplt;

  modport master (
    input  req,
    input  req_cmd,
    input  cmd_cmplt,
    output ack,
    output busy,
    output cur_id,
    output snd_cmd,
    output cmd
  );

  modport slave (
    output req,
    output req_cmd,
    output cmd_cmplt,
    input  ack,
    input  busy,
    input  cur_id,
    input  snd_cmd,
    input  cmd
  );
endinterface

// File: rtl/comm_cmd_arbiter.sv
// Round-robin arbiter sharing one command transmitter among NUM_REQ sources.
// Latches the winning command and holds it until the transmitter completes.
module comm_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 16,
  parameter int GAP_CYC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  comm_cmd_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_REQ-1:0] ack;
  logic               busy;
  logic               snd_cmd;
  logic [CMD_W-1:0]   cmd;

  // First set request at or above ptr, wrapping modulo NUM_REQ
  always_comb begin
    int idx;
    found    = 1'b0;
    grant_id = ptr;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur_id  <= '0;
      gap_cnt <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      snd_cmd <= 1'b0;
      cmd     <= '0;
    end else begin
      snd_cmd <= 1'b0;
      ack     <= '0;
      unique case (state)
        IDLE: begin
          // the ack cycle is never a grant cycle, so a late req drop is safe
          if (found && ack == '0) begin
            state   <= LAUNCH;
            cmd     <= bus.req_cmd[int'(grant_id)*CMD_W +: CMD_W];
            cur_id  <= grant_id;
            snd_cmd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.cmd_cmplt) begin
            ack <= NUM_REQ'(1) << cur_id;
            ptr <= (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
            if (GAP_CYC > 0) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          // ack cycle plus GAP_CYC idle cycles before IDLE may grant
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack     = ack;
  assign bus.busy    = busy;
  assign bus.cur_id  = cur_id;
  assign bus.snd_cmd = snd_cmd;
  assign bus.cmd     = cmd;
endmodule

// File: tb/tb_comm_cmd_arbiter.sv
// Directed bench for comm_cmd_arbiter: one instance without gap, one with
// a five-cycle gap.
module tb_comm_cmd_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  comm_cmd_arbiter_if #(.NUM_REQ(4), .CMD_W(16)) ia ();
  comm_cmd_arbiter_if #(.NUM_REQ(4), .CMD_W(16)) ib ();

  comm_cmd_arbiter #(.NUM_REQ(4), .CMD_W(16), .GAP_CYC(0)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ia)
  );

  comm_cmd_arbiter #(.NUM_REQ(4), .CMD_W(16), .GAP_CYC(5)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int id);
    int n;
    n = 0;
    while (!ia.snd_cmd && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(ia.snd_cmd), 32'd1);
    id = int'(ia.cur_id);
  endtask

  task automatic finish_cmd(input int id);
    tick();
    chk("snd_one_cycle", 32'(ia.snd_cmd), 32'd0);
    ia.cmd_cmplt = 1'b1;
    tick();
    ia.cmd_cmplt = 1'b0;
    chk("ack", 32'(ia.ack), 32'd1 << id);
    chk("busy_after", 32'(ia.busy), 32'd0);
    ia.req[id] = 1'b0;
    tick();
    chk("ack_clear", 32'(ia.ack), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int id;
    int n;
    int fair_exp[4];
    total = 0;
    bad   = 0;
    fair_exp = '{0, 2, 0, 2};
    ia.req = '0;
    ia.req_cmd = '0;
    ia.cmd_cmplt = 1'b0;
    ib.req = '0;
    ib.req_cmd = '0;
    ib.cmd_cmplt = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_snd", 32'(ia.snd_cmd), 32'd0);
    chk("rst_ack", 32'(ia.ack), 32'd0);
    chk("rst_busy", 32'(ia.busy), 32'd0);
    chk("rst_cmd", 32'(ia.cmd), 32'd0);
    chk("rst_id", 32'(ia.cur_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request
    ia.req_cmd[31:16] = 16'hA55A;
    ia.req = 4'b0010;
    tick();
    chk("single_snd", 32'(ia.snd_cmd), 32'd1);
    chk("single_cmd", 32'(ia.cmd), 32'hA55A);
    chk("single_id", 32'(ia.cur_id), 32'd1);
    chk("single_busy", 32'(ia.busy), 32'd1);
    finish_cmd(1);

    // round robin from a fresh pointer
    do_reset();
    ia.req_cmd = 64'h3333_2222_1111_0000;
    ia.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(id);
      chk("rr_id", 32'(id), 32'(k));
      chk("rr_cmd", 32'(ia.cmd), 32'(k) * 32'h1111);
      finish_cmd(id);
    end
    ia.req = 4'b1001;
    wait_grant(id);
    chk("rr_wrap_id", 32'(id), 32'd0);
    finish_cmd(id);
    wait_grant(id);
    chk("rr_then3", 32'(id), 32'd3);
    finish_cmd(id);

    // fairness: both re-raise after each ack
    ia.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_grant(id);
      chk("fair_id", 32'(id), 32'(fair_exp[k]));
      finish_cmd(id);
      if (k < 3) ia.req[id] = 1'b1;
    end
    ia.req = '0;
    tick();
    tick();
    chk("fair_idle", 32'(ia.busy), 32'd0);

    // stability; pointer is 3 so this also wraps to 0
    ia.req_cmd[15:0] = 16'h1234;
    ia.req = 4'b0001;
    wait_grant(id);
    chk("stab_id", 32'(id), 32'd0);
    chk("stab_cmd0", 32'(ia.cmd), 32'h1234);
    ia.req_cmd[15:0] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stab_hold", 32'(ia.cmd), 32'h1234);
    end
    finish_cmd(0);

    // reset while waiting; pointer is 1 so grant goes to 3
    ia.req = 4'b1000;
    wait_grant(id);
    chk("mid_id", 32'(id), 32'd3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_snd", 32'(ia.snd_cmd), 32'd0);
    chk("mid_rst_busy", 32'(ia.busy), 32'd0);
    chk("mid_rst_ack", 32'(ia.ack), 32'd0);
    chk("mid_rst_cmd", 32'(ia.cmd), 32'd0);
    chk("mid_rst_id", 32'(ia.cur_id), 32'd0);
    tick();
    chk("mid_rst_noack", 32'(ia.ack), 32'd0);
    rst_n = 1'b1;
    ia.req = 4'b1001;
    wait_grant(id);
    chk("post_rst_id", 32'(id), 32'd0);
    finish_cmd(id);
    wait_grant(id);
    chk("post_rst_id3", 32'(id), 32'd3);
    finish_cmd(id);

    // stray completion in idle
    ia.cmd_cmplt = 1'b1;
    tick();
    ia.cmd_cmplt = 1'b0;
    chk("stray_ack", 32'(ia.ack), 32'd0);
    chk("stray_busy", 32'(ia.busy), 32'd0);
    tick();
    chk("stray_ack2", 32'(ia.ack), 32'd0);

    // gap instance: ack cycle, 5 idle cycles, grant cycle, then snd_cmd
    ib.req_cmd = 64'h0000_0000_BBBB_AAAA;
    ib.req = 4'b0011;
    n = 0;
    while (!ib.snd_cmd && n < 20) begin
      tick();
      n++;
    end
    chk("gap_g0", 32'(ib.snd_cmd), 32'd1);
    chk("gap_id0", 32'(ib.cur_id), 32'd0);
    chk("gap_cmd0", 32'(ib.cmd), 32'hAAAA);
    tick();
    ib.cmd_cmplt = 1'b1;
    tick();
    ib.cmd_cmplt = 1'b0;
    chk("gap_ack0", 32'(ib.ack), 32'd1);
    chk("gap_busy", 32'(ib.busy), 32'd1);
    ib.req[0] = 1'b0;
    n = 0;
    while (!ib.snd_cmd && n < 30) begin
      if (n == 2) ib.cmd_cmplt = 1'b1;
      tick();
      ib.cmd_cmplt = 1'b0;
      n++;
      if (n == 3) chk("gap_stray_ack", 32'(ib.ack), 32'd0);
    end
    chk("gap_len", 32'(n), 32'd7);
    chk("gap_id1", 32'(ib.cur_id), 32'd1);
    chk("gap_cmd1", 32'(ib.cmd), 32'hBBBB);
    tick();
    ib.cmd_cmplt = 1'b1;
    tick();
    ib.cmd_cmplt = 1'b0;
    chk("gap_ack1", 32'(ib.ack), 32'd2);
    ib.req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
